// File: rtl/ramdata_arbiter.sv
// ramdata_arbiter: shares one ramdata (one write port, one registered read
// port) between NUM_REQ round-robin readers and a single always-winning writer.
// A read that hits the address being written in the same cycle is held off one
// cycle so it returns post-write data. Each response carries the requester ID.
// The en/busy handshake lets the RAM be quiesced between LSTM time steps.
// Optional macro RSP_REG_EN adds one register stage on the response path.
// That stage makes the read latency 2 cycles and stretches DRAIN to 2 cycles.
module ramdata_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 4,
    parameter int DATA_W  = 8,
    parameter int ID_W    = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    output logic                      busy,
    input  logic [NUM_REQ-1:0]        rd_req,
    input  logic [NUM_REQ*ADDR_W-1:0] rd_addr,
    output logic [NUM_REQ-1:0]        rd_gnt,
    output logic                      rsp_valid,
    output logic [ID_W-1:0]           rsp_id,
    output logic [DATA_W-1:0]         rsp_data,
    input  logic                      wr_req,
    input  logic [ADDR_W-1:0]         wr_addr,
    input  logic [DATA_W-1:0]         wr_data,
    output logic                      wr_ack,
    output logic                      ram_cs,
    output logic                      ram_wr_en,
    output logic [ADDR_W-1:0]         ram_wr_addr,
    output logic [DATA_W-1:0]         ram_wr_data,
    output logic                      ram_rd_en,
    output logic [ADDR_W-1:0]         ram_rd_addr,
    input  logic [DATA_W-1:0]         ram_rd_data
);

`ifdef RSP_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t              r_state, w_next;
    logic [ID_W-1:0]     r_rr_ptr;
    logic                r_vld;         // read granted last cycle (in flight)
    logic [ID_W-1:0]     r_id;
    logic                r_drain_left;  // extra DRAIN cycles still owed

    logic                w_run, w_busy, w_found, w_collide, w_grant;
    logic [ID_W-1:0]     w_win, w_ptr_nxt;
    logic [ADDR_W-1:0]   w_win_addr;

    // Outputs are forced quiet while reset is asserted so that an in-flight
    // read never surfaces as a response during the reset cycle.
    assign w_run  = rst_n && (r_state == S_RUN);
    assign w_busy = rst_n && (r_state != S_IDLE);

    // Round-robin search: indices at/after the pointer first, then wrap.
    always_comb begin
        w_found    = 1'b0;
        w_win      = '0;
        w_win_addr = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_found && rd_req[i] && (i >= int'(r_rr_ptr))) begin
                w_found    = 1'b1;
                w_win      = ID_W'(i);
                w_win_addr = rd_addr[i*ADDR_W +: ADDR_W];
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_found && rd_req[i] && (i < int'(r_rr_ptr))) begin
                w_found    = 1'b1;
                w_win      = ID_W'(i);
                w_win_addr = rd_addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    // A same-address write wins; the reader retries next cycle and sees new data.
    assign w_collide = w_found && wr_req && (w_win_addr == wr_addr);
    assign w_grant   = w_run && w_found && !w_collide;
    assign w_ptr_nxt = (w_win == ID_W'(NUM_REQ-1)) ? '0 : w_win + 1'b1;

    // One-hot grant decode of the winner.
    always_comb begin
        rd_gnt = '0;
        for (int i = 0; i < NUM_REQ; i++)
            rd_gnt[i] = w_grant && (w_win == ID_W'(i));
    end

    assign busy        = w_busy;
    assign ram_cs      = w_busy;
    assign wr_ack      = w_run && wr_req;
    assign ram_wr_en   = wr_ack;
    assign ram_wr_addr = wr_ack ? wr_addr : '0;
    assign ram_wr_data = wr_ack ? wr_data : '0;
    assign ram_rd_en   = w_grant;
    assign ram_rd_addr = w_grant ? w_win_addr : '0;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next state: RUN drains only if a read was just launched.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (en) w_next = S_RUN;
            S_RUN:   if (!en) w_next = w_grant ? S_DRAIN : S_IDLE;
            S_DRAIN: if (r_drain_left == 1'b0) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Pointer, in-flight flag, response tag and drain countdown.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rr_ptr     <= '0;
            r_vld        <= 1'b0;
            r_id         <= '0;
            r_drain_left <= 1'b0;
        end else begin
            r_vld <= w_grant;
            if (w_grant) begin
                r_id     <= w_win;
                r_rr_ptr <= w_ptr_nxt;
            end
            if (r_state == S_RUN && !en && w_grant)
                r_drain_left <= 1'(LAT-1);
            else if (r_state == S_DRAIN && r_drain_left != 1'b0)
                r_drain_left <= r_drain_left - 1'b1;
        end
    end

`ifdef RSP_REG_EN
    logic              r_vld2;
    logic [ID_W-1:0]   r_id2;
    logic [DATA_W-1:0] r_data2;

    // Extra response register stage.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_vld2  <= 1'b0;
            r_id2   <= '0;
            r_data2 <= '0;
        end else begin
            r_vld2  <= r_vld;
            r_id2   <= r_id;
            r_data2 <= r_vld ? ram_rd_data : '0;
        end
    end

    assign rsp_valid = rst_n && r_vld2;
    assign rsp_id    = r_id2;
    assign rsp_data  = r_data2;
`else
    assign rsp_valid = rst_n && r_vld;
    assign rsp_id    = r_id;
    assign rsp_data  = r_vld ? ram_rd_data : '0;
`endif

endmodule

// File: tb/tb_ramdata_arbiter.sv
// Bench for ramdata_arbiter: a small RAM, a cycle-level reference model with
// a response queue, one negedge compare process, and directed test vectors
// whose grant/response logs are pinned against hand-computed literals.
module tb_ramdata_arbiter;

`ifdef RSP_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst_n, en;
    logic [3:0]  rd_req;
    logic [15:0] rd_addr;
    logic        wr_req;
    logic [3:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        busy, rsp_valid, wr_ack, ram_cs, ram_wr_en, ram_rd_en;
    logic [3:0]  rd_gnt, ram_wr_addr, ram_rd_addr;
    logic [1:0]  rsp_id;
    logic [7:0]  rsp_data, ram_wr_data;
    logic [7:0]  ram_q = 8'h00;

    ramdata_arbiter #(.NUM_REQ(4), .ADDR_W(4), .DATA_W(8), .ID_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .busy(busy),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
        .ram_cs(ram_cs), .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr),
        .ram_wr_data(ram_wr_data), .ram_rd_en(ram_rd_en),
        .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_q)
    );

    always #5 clk = ~clk;

    // RAM: preloaded with mem[k] = k*16, registered read, read-old on conflict.
    logic [7:0] ram [16];
    logic       ram_loaded = 1'b0;
    always @(posedge clk) begin
        if (!ram_loaded) begin
            for (int k = 0; k < 16; k++) ram[k] <= 8'(k*16);
            ram_loaded <= 1'b1;
        end else begin
            if (ram_cs && ram_wr_en) ram[ram_wr_addr] <= ram_wr_data;
            if (ram_cs && ram_rd_en) ram_q <= ram[ram_rd_addr];
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- reference model + observation logs ----------------
    typedef struct { int due; int id; int data; } rsp_t;
    rsp_t       rq[$];
    logic [7:0] shadow [16];
    int         cyc = 0;
    int         m_state = 0;   // 0 idle, 1 run, 2 drain
    int         m_left = 0, m_ptr = 0, m_win;
    logic       m_run, m_busy, m_coll, m_rv;
    logic [3:0] m_gnt;
    int         gnt_log[$];
    int         rsp_log[$];
    int         busy_cnt = 0, both_cnt = 0;

    function automatic logic [3:0] ra(input int i);
        return rd_addr[i*4 +: 4];
    endfunction

    always @(negedge clk) begin
        cyc++;
        if (cyc == 1) for (int k = 0; k < 16; k++) shadow[k] = 8'(k*16);
        for (int k = 0; k < N; k++) if (rd_gnt[k]) gnt_log.push_back(k);
        if (rsp_valid) rsp_log.push_back(int'(rsp_id)*256 + int'(rsp_data));
        if (busy) busy_cnt++;
        if (rd_gnt != 0 && wr_ack) both_cnt++;
        if (!rst_n) begin
            chk("reset_ctl", {busy, ram_cs, rd_gnt, wr_ack, ram_wr_en, ram_rd_en, rsp_valid}, 0);
            chk("reset_ram_addr", {ram_wr_addr, ram_rd_addr, ram_wr_data}, 0);
            m_state = 0; m_ptr = 0; rq.delete();
        end else begin
            m_run  = (m_state == 1);
            m_busy = (m_state != 0);
            m_win  = -1;
            for (int k = 0; k < N; k++)
                if (m_win < 0 && rd_req[(m_ptr + k) % N]) m_win = (m_ptr + k) % N;
            m_coll = m_run && m_win >= 0 && wr_req && ra(m_win) == wr_addr;
            m_gnt  = (m_run && m_win >= 0 && !m_coll) ? 4'(1 << m_win) : 4'd0;
            m_rv   = rq.size() > 0 && rq[0].due == cyc;
            chk("busy", busy, m_busy);
            chk("ram_cs", ram_cs, m_busy);
            chk("rd_gnt", rd_gnt, m_gnt);
            chk("wr_ack", wr_ack, m_run && wr_req);
            chk("ram_wr_en", ram_wr_en, m_run && wr_req);
            chk("ram_wr_addr", ram_wr_addr, (m_run && wr_req) ? wr_addr : 4'd0);
            chk("ram_wr_data", ram_wr_data, (m_run && wr_req) ? wr_data : 8'd0);
            chk("ram_rd_en", ram_rd_en, m_gnt != 0);
            chk("ram_rd_addr", ram_rd_addr, (m_gnt != 0) ? ra(m_win) : 4'd0);
            chk("rsp_valid", rsp_valid, m_rv);
            if (m_rv) begin
                chk("rsp_id", rsp_id, rq[0].id);
                chk("rsp_data", rsp_data, rq[0].data);
                void'(rq.pop_front());
            end
            if (m_gnt != 0) begin
                rq.push_back('{cyc + LAT, m_win, int'(shadow[ra(m_win)])});
                m_ptr = (m_win + 1) % N;
            end
            if (m_run && wr_req) shadow[wr_addr] = wr_data;
            case (m_state)
                0: if (en) m_state = 1;
                1: if (!en) begin
                       if (m_gnt != 0) begin m_state = 2; m_left = LAT; end
                       else m_state = 0;
                   end
                default: begin m_left--; if (m_left == 0) m_state = 0; end
            endcase
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_addr(input int i, input logic [3:0] a);
        rd_addr[i*4 +: 4] = a;
    endtask

    task automatic chk_logs(input string nm, input int gb, input int rb,
                            input int eg[$], input int er[$]);
        chk({nm, "_ngnt"}, gnt_log.size() - gb, eg.size());
        chk({nm, "_nrsp"}, rsp_log.size() - rb, er.size());
        for (int k = 0; k < eg.size(); k++)
            if (gb + k < gnt_log.size()) chk({nm, "_gnt"}, gnt_log[gb+k], eg[k]);
        for (int k = 0; k < er.size(); k++)
            if (rb + k < rsp_log.size()) chk({nm, "_rsp"}, rsp_log[rb+k], er[k]);
    endtask

    int gb, rb, bb, bo;
    int eg[$];
    int er[$];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; en = 1'b0; rd_req = '0; rd_addr = '0;
        wr_req = 1'b0; wr_addr = '0; wr_data = '0;
        step(3);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_busy", busy, 0);
        chk("post_reset_cs", ram_cs, 0);
        chk("post_reset_rsp", {rsp_valid, rsp_id, rsp_data}, 0);
        step(1);

        // Round robin with all four requesting addrs 1..4.
        gb = gnt_log.size(); rb = rsp_log.size();
        en = 1'b1; rd_req = 4'hF;
        for (int i = 0; i < N; i++) set_addr(i, 4'(i+1));
        step(6);
        rd_req = '0;
        step(LAT + 1);
        eg = '{0, 1, 2, 3, 0};
        er = '{16'h0010, 16'h0120, 16'h0230, 16'h0340, 16'h0010};
        chk_logs("rr", gb, rb, eg, er);

        // Sparse: only 3 (addr 9), then only 1; pointer wraps.
        gb = gnt_log.size(); rb = rsp_log.size();
        set_addr(3, 4'd9); rd_req = 4'b1000; step(1);
        rd_req = 4'b0010; step(1);
        rd_req = '0; step(LAT + 1);
        eg = '{3, 1};
        er = '{16'h0390, 16'h0120};
        chk_logs("sparse", gb, rb, eg, er);

        // Collision: read 2 at addr 5 with write 5 <- A5.
        gb = gnt_log.size(); rb = rsp_log.size(); bo = both_cnt;
        set_addr(2, 4'd5); rd_req = 4'b0100;
        wr_req = 1'b1; wr_addr = 4'd5; wr_data = 8'hA5;
        step(1);
        wr_req = 1'b0; step(1);
        rd_req = '0; step(LAT + 1);
        eg = '{2};
        er = '{16'h02A5};
        chk_logs("coll", gb, rb, eg, er);
        chk("coll_no_same_cycle", both_cnt - bo, 0);

        // Write 3 <- 77 with read 1 at addr 6 in the same cycle.
        gb = gnt_log.size(); rb = rsp_log.size(); bo = both_cnt;
        set_addr(1, 4'd6); rd_req = 4'b0010;
        wr_req = 1'b1; wr_addr = 4'd3; wr_data = 8'h77;
        step(1);
        wr_req = 1'b0; rd_req = '0; step(LAT + 1);
        eg = '{1};
        er = '{16'h0160};
        chk_logs("wrdiff", gb, rb, eg, er);
        chk("wrdiff_same_cycle", both_cnt - bo, 1);

        // Drain: grant to 0 (addr 3, now 77) in the cycle en falls.
        gb = gnt_log.size(); rb = rsp_log.size(); bb = busy_cnt;
        set_addr(0, 4'd3); rd_req = 4'b0001; en = 1'b0;
        step(1);
        rd_req = '0; step(LAT);
        @(negedge clk);
        chk("drain_idle_cs", ram_cs, 0);
        step(0);
        rd_req = 4'b0001; step(2);
        rd_req = '0; step(1);
        eg = '{0};
        er = '{16'h0077};
        chk_logs("drain", gb, rb, eg, er);
        chk("drain_busy_cycles", busy_cnt - bb, 1 + LAT);

        // Mid-read reset: response dropped, pointer back to 0.
        gb = gnt_log.size(); rb = rsp_log.size();
        set_addr(1, 4'd7); set_addr(3, 4'd8);
        en = 1'b1; rd_req = 4'b1010; step(2);
        rst_n = 1'b0; rd_req = 4'b1000; step(1);
        rst_n = 1'b1; rd_req = 4'b1010; step(2);
        rd_req = '0; step(LAT + 1);
        eg = '{1, 1};
        er = '{16'h0170};
        chk_logs("midrst", gb, rb, eg, er);

        en = 1'b0;
        step(3);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ramdata_arbiter.md
Name: ramdata_arbiter

Overview:
Shares one ramdata instance (one write port, one registered read port) between NUM_REQ read requesters and one write requester in the LSTM decoding datapath.
- Read port: round-robin arbitration across requesters.
- Write port: always wins.
- Same-address read/write collisions are stalled so readers never get stale data.
- Each read response is tagged with the requester ID.
- Enable/drain sequencing allows the RAM to be quiesced between LSTM time steps.

Parameters:
NUM_REQ, 4, number of read requesters (2..8)
ADDR_W, 4, RAM address width
DATA_W, 8, RAM data width
ID_W, 2, requester ID width; must satisfy 2^ID_W >= NUM_REQ

Ports:
clk  in  1  single clock; drives this block and the ramdata clka/clkb
rst_n  in  1  synchronous, active-low reset
en  in  1  enable; high = arbitrate, low = drain then idle
busy  out  1  high in RUN and DRAIN
rd_req  in  NUM_REQ  per-requester read request; held until granted
rd_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i at bits [i*ADDR_W +: ADDR_W]
rd_gnt  out  NUM_REQ  one-hot grant pulse on the acceptance cycle
rsp_valid  out  1  read response valid
rsp_id  out  ID_W  requester index of the response
rsp_data  out  DATA_W  read data
wr_req  in  1  write request
wr_addr  in  ADDR_W  write address
wr_data  in  DATA_W  write data
wr_ack  out  1  write accepted this cycle
ram_cs  out  1  to ramdata cs
ram_wr_en  out  1  to ramdata wr_en
ram_wr_addr  out  ADDR_W  to ramdata wr_addr
ram_wr_data  out  DATA_W  to ramdata wr_data
ram_rd_en  out  1  to ramdata rd_en
ram_rd_addr  out  ADDR_W  to ramdata rd_addr
ram_rd_data  in  DATA_W  from ramdata rd_data (valid 1 cycle after ram_rd_en)

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE, rr_ptr=0, in-flight flag=0.
  - rsp_valid=0, rsp_id=0, rsp_data=0, busy=0.
  - rd_gnt, wr_ack and all ram_* outputs are 0.
  - Reset mid-read discards the in-flight read; no response is issued.
- FSM:
  - IDLE: ram_cs=0, no grants, no acks. en=1 -> RUN.
  - RUN: arbitrate. en=0 -> DRAIN if a read was granted this cycle, else -> IDLE.
  - DRAIN: no new grants or acks; the outstanding response is delivered; -> IDLE next cycle.
- Write (combinational in RUN only):
  - wr_ack = wr_req.
  - ram_wr_en = wr_req; ram_wr_addr and ram_wr_data pass through.
  - Writes are never stalled.
- Read arbitration (RUN):
  - Winner = first i with rd_req[i]=1, searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
- Collision: if wr_req=1 and the winner's address equals wr_addr:
  - No grant this cycle; rr_ptr unchanged.
  - The same winner is re-evaluated next cycle, which returns the post-write data.
- Grant: rd_gnt[winner]=1, ram_rd_en=1, ram_rd_addr = winner's address.
  - rr_ptr <= (winner+1) mod NUM_REQ.
  - Winner ID is registered for tagging.
- Response latency: rsp_valid=1 exactly 1 cycle after rd_gnt.
  - rsp_id = registered ID; rsp_data = ram_rd_data.
  - Back-to-back grants give back-to-back responses (throughput 1 read/cycle).
- Outputs are combinational:
  - ram_cs = busy.
  - rd_gnt is combinational from rd_req and state.
  - rsp_valid/rsp_id are registered.
- No request pending: rr_ptr holds; ram_rd_en=0.
- en dropping with no read in flight: RUN -> IDLE directly.
- en re-asserted during DRAIN: ignored; the FSM returns to RUN via IDLE.

Optional Feature:
RSP_REG_EN: when defined, rsp_valid, rsp_id and rsp_data pass through an extra register stage.
- Read latency becomes 2 cycles from rd_gnt; reset value 0.
- DRAIN lasts 2 cycles.
- When undefined, latency is 1 and rsp_data is combinational from ram_rd_data.

Test Plan:
- Reset then en=1, all four rd_req held, addrs 1,2,3,4 (RAM preloaded addr k=k*16):
  - Grants rotate 0,1,2,3,0 on consecutive cycles.
  - Responses have rsp_id 0,1,2,3 and data 0x10,0x20,0x30,0x40, one cycle after each grant.
- Collision: wr_req=1, wr_addr=5, wr_data=0xA5 in the same cycle as rd_req[2]=1 with addr 5:
  - No grant that cycle; rd_gnt[2] the next cycle.
  - rsp_data=0xA5, rsp_id=2.
- Write with read to a different address (wr 3<-0x77, rd_req[1] on addr 6):
  - wr_ack=1 and rd_gnt[1]=1 in the same cycle.
  - rsp_data = old value at 6.
- Drain: grant to requester 0 in the cycle en falls:
  - busy stays high 1 cycle (2 with RSP_REG_EN); rsp_valid delivered; then IDLE with ram_cs=0.
  - rd_req asserted in IDLE gets no grant.
- Mid-read reset: rst_n=0 the cycle after a grant:
  - rsp_valid=0; rr_ptr=0; first grant after reset goes to the lowest requesting index.
- Sparse requests (only rd_req[3], then only rd_req[1]):
  - Each is granted immediately.
  - rr_ptr wraps 3 -> 0; next grant goes to 1.
